// File: rtl/sha_message_schedule_sequencer.sv
// SHA-256 message schedule sequencer.
// Accepts one 512-bit message block and streams the schedule words
// W_0..W_{NUM_ROUNDS-1} over a valid/ready interface, one word per
// accepted transfer.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   block_valid_i  a message block is offered on block_i
//   block_ready_o  registered; high while idle and able to accept a block
//   block_i        block_i[t] = message word M_t (t = 0 is the first word)
//   w_valid_o      w_o / round_o / last_o hold a valid schedule word
//   w_ready_i      downstream accepts the current word
//   w_o            schedule word W_t
//   round_o        index t of w_o
//   last_o         high iff round_o == NUM_ROUNDS-1
module sha_message_schedule_sequencer #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              block_valid_i,
  output logic              block_ready_o,
  input  logic [15:0][31:0] block_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [31:0]       w_o,
  output logic [5:0]        round_o,
  output logic              last_o
);

  localparam logic [5:0] LAST_ROUND  = 6'(NUM_ROUNDS - 1);
  localparam logic [6:0] ROUND_LIMIT = 7'(NUM_ROUNDS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_next;

  // The window holds W_t..W_{t+15}: entry 15 is the word being presented
  // (W_t), entry 0 is the most recently produced word (W_{t+15}). Keeping
  // the next sixteen words ready lets W_{t+1} be presented straight from
  // entry 14 on every transfer, with no combinational path to w_o.
  logic [31:0] window [16];

  logic        accept;
  logic        xfer;
  logic        expand_en;
  logic [31:0] expand_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_comb begin
    state_next = state;
    accept     = (state == IDLE) && block_ready_o && block_valid_i;
    xfer       = (state == RUN) && w_valid_o && w_ready_i;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (xfer && last_o) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t. It is only
  // produced when it will actually be emitted; otherwise zero is shifted in.
  always_comb begin
    expand_word = sig1(window[1]) + window[6] + sig0(window[14]) + window[15];
    expand_en   = ({1'b0, round_o} + 7'd16) < ROUND_LIMIT;
  end

  assign w_o = window[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_ready_o <= 1'b0;
      w_valid_o     <= 1'b0;
      round_o       <= '0;
      last_o        <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
        window[k] <= '0;
      end
    end else begin
      block_ready_o <= (state_next == IDLE);
      if (accept) begin
        for (int unsigned k = 0; k < 16; k++) begin
          window[k] <= block_i[15 - k];
        end
        w_valid_o <= 1'b1;
        round_o   <= '0;
        last_o    <= 1'b0;
      end else if (xfer) begin
        for (int unsigned k = 1; k < 16; k++) begin
          window[k] <= window[k - 1];
        end
        window[0] <= expand_en ? expand_word : '0;
        if (last_o) begin
          w_valid_o <= 1'b0;
          last_o    <= 1'b0;
        end else begin
          round_o <= round_o + 6'd1;
          last_o  <= ((round_o + 6'd1) == LAST_ROUND);
        end
      end
    end
  end

endmodule

// File: tb/tb_sha_message_schedule_sequencer.sv
module tb_sha_message_schedule_sequencer;

  logic              clk;
  logic              rst_n;
  logic              block_valid;
  logic              block_ready;
  logic [15:0][31:0] block;
  logic              w_valid;
  logic              w_ready;
  logic [31:0]       w_word;
  logic [5:0]        round;
  logic              last;

  logic              block16_valid;
  logic              block16_ready;
  logic [15:0][31:0] block16;
  logic              w16_valid;
  logic              w16_ready;
  logic [31:0]       w16_word;
  logic [5:0]        round16;
  logic              last16;

  sha_message_schedule_sequencer #(.NUM_ROUNDS(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .block_valid_i (block_valid),
    .block_ready_o (block_ready),
    .block_i       (block),
    .w_valid_o     (w_valid),
    .w_ready_i     (w_ready),
    .w_o           (w_word),
    .round_o       (round),
    .last_o        (last)
  );

  sha_message_schedule_sequencer #(.NUM_ROUNDS(16)) dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .block_valid_i (block16_valid),
    .block_ready_o (block16_ready),
    .block_i       (block16),
    .w_valid_o     (w16_valid),
    .w_ready_i     (w16_ready),
    .w_o           (w16_word),
    .round_o       (round16),
    .last_o        (last16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ew;
    logic [5:0]  eround;
    logic        elast;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0][31:0] abc;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule, pushed to the scoreboard when a block is driven.
  task automatic push_block(input logic [15:0][31:0] blk, input int nr);
    logic [31:0] wm [64];
    exp_t e;
    for (int t = 0; t < nr; t++) begin
      if (t < 16) wm[t] = blk[t];
      else        wm[t] = s1(wm[t-2]) + wm[t-7] + s0(wm[t-15]) + wm[t-16];
      e.ew     = wm[t];
      e.eround = 6'(t);
      e.elast  = (t == nr - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_block(input logic [15:0][31:0] blk);
    @(posedge clk); #1;
    block       = blk;
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
  endtask

  task automatic random_block(output logic [15:0][31:0] blk);
    for (int k = 0; k < 16; k++) blk[k] = $urandom;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({block_ready, w_valid, w_word, round, last} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b/%b/%h/%0d/%b required all zero",
               block_ready, w_valid, w_word, round, last);
    end
    n_cmp++;
    if ({block16_ready, w16_valid, w16_word, round16, last16} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs16: got %b/%b/%h/%0d/%b required all zero",
               block16_ready, w16_valid, w16_word, round16, last16);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (block_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_before_edge: got %b required 0", block_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (block_ready !== 1'b1 || block16_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_edge: got %b/%b required 1/1", block_ready, block16_ready);
    end
  endtask

  task automatic test_abc;
    exp_t e;
    int   cnt = 0;
    q.delete();
    push_block(abc, 64);
    w_ready = 1'b1;
    send_block(abc);
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      @(negedge clk);
      if (w_valid && w_ready) begin
        e = q.pop_front();
        cnt++;
        n_cmp++;
        if ({w_word, round, last} !== {e.ew, e.eround, e.elast}) begin
          n_bad++;
          $display("FAIL abc_word: got w=%h r=%0d l=%b required w=%h r=%0d l=%b",
                   w_word, round, last, e.ew, e.eround, e.elast);
        end
        if (round == 6'd0 || round == 6'd15 || round == 6'd16 || round == 6'd17) begin
          n_cmp++;
          if ((round == 6'd0  && w_word !== 32'h61626380) ||
              (round == 6'd15 && w_word !== 32'h00000018) ||
              (round == 6'd16 && w_word !== 32'h61626380) ||
              (round == 6'd17 && w_word !== 32'h000F0000)) begin
            n_bad++;
            $display("FAIL abc_known_word: round %0d got %h", round, w_word);
          end
        end
      end
    end
    n_cmp++;
    if (q.size() != 0 || cnt != 64) begin
      n_bad++;
      $display("FAIL abc_count: got %0d words required 64 (left %0d)", cnt, q.size());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (w_valid !== 1'b0 || block_ready !== 1'b1 || last !== 1'b0) begin
      n_bad++;
      $display("FAIL abc_end: got valid=%b ready=%b last=%b required 0/1/0",
               w_valid, block_ready, last);
    end
  endtask

  task automatic test_stall;
    exp_t        e;
    logic        stalled = 1'b0;
    logic [39:0] snap = '0;
    q.delete();
    push_block(abc, 64);
    w_ready = 1'($urandom_range(0, 1));
    send_block(abc);
    for (int c = 0; c < 1000 && q.size() > 0; c++) begin
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if ({w_valid, w_word, round, last} !== snap) begin
          n_bad++;
          $display("FAIL stall_hold: got %h required %h", {w_valid, w_word, round, last}, snap);
        end
      end
      if (w_valid && w_ready) begin
        e = q.pop_front();
        n_cmp++;
        if ({w_word, round, last} !== {e.ew, e.eround, e.elast}) begin
          n_bad++;
          $display("FAIL stall_word: got w=%h r=%0d l=%b required w=%h r=%0d l=%b",
                   w_word, round, last, e.ew, e.eround, e.elast);
        end
      end
      stalled = w_valid && !w_ready;
      snap    = {w_valid, w_word, round, last};
      @(posedge clk); #1;
      w_ready = 1'($urandom_range(0, 1));
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL stall_timeout: got %0d words left required 0", q.size());
    end
    w_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [15:0][31:0] blk_a;
    logic [15:0][31:0] blk_b;
    exp_t e;
    int   accepts = 0, low = 0, cyc = 0;
    int   last_cyc = -100, acc2_cyc = -1;
    logic lat_done = 1'b0;
    random_block(blk_a);
    random_block(blk_b);
    q.delete();
    push_block(blk_a, 64);
    push_block(blk_b, 64);
    w_ready = 1'b1;
    @(posedge clk); #1;
    block       = blk_a;
    block_valid = 1'b1;
    for (int c = 0; c < 400 && q.size() > 0; c++) begin
      @(negedge clk);
      cyc++;
      if (block_ready && block_valid) begin
        accepts++;
        if (accepts == 2) acc2_cyc = cyc;
      end else if (accepts == 1 && !block_ready) begin
        low++;
      end
      if (w_valid && w_ready) begin
        e = q.pop_front();
        n_cmp++;
        if ({w_word, round, last} !== {e.ew, e.eround, e.elast}) begin
          n_bad++;
          $display("FAIL b2b_word: got w=%h r=%0d l=%b required w=%h r=%0d l=%b",
                   w_word, round, last, e.ew, e.eround, e.elast);
        end
        if (last && accepts == 1) last_cyc = cyc;
      end
      @(posedge clk); #1;
      if (accepts == 1 && !lat_done) begin
        lat_done = 1'b1;
        n_cmp++;
        if (w_valid !== 1'b1 || round !== 6'd0 || w_word !== blk_a[0] || block_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_latency: got v=%b r=%0d w=%h rdy=%b required 1/0/%h/0",
                   w_valid, round, w_word, block_ready, blk_a[0]);
        end
        block = blk_b;
      end
      if (accepts == 2) block_valid = 1'b0;
    end
    n_cmp++;
    if (low != 64) begin
      n_bad++;
      $display("FAIL b2b_ready_low: got %0d cycles required 64", low);
    end
    n_cmp++;
    if (acc2_cyc - last_cyc != 1) begin
      n_bad++;
      $display("FAIL b2b_bubble: got %0d cycles required 1", acc2_cyc - last_cyc);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_timeout: got %0d words left required 0", q.size());
    end
    block_valid = 1'b0;
  endtask

  task automatic test_block_change;
    logic [15:0][31:0] blk_c;
    logic [15:0][31:0] junk;
    exp_t e;
    random_block(blk_c);
    q.delete();
    push_block(blk_c, 64);
    w_ready = 1'b1;
    send_block(blk_c);
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      @(negedge clk);
      if (w_valid && w_ready) begin
        e = q.pop_front();
        n_cmp++;
        if ({w_word, round, last} !== {e.ew, e.eround, e.elast}) begin
          n_bad++;
          $display("FAIL change_word: got w=%h r=%0d l=%b required w=%h r=%0d l=%b",
                   w_word, round, last, e.ew, e.eround, e.elast);
        end
      end
      random_block(junk);
      block = junk;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL change_timeout: got %0d words left required 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midreset;
    logic [15:0][31:0] blk_d;
    exp_t e;
    logic hit = 1'b0;
    q.delete();
    push_block(abc, 64);
    w_ready = 1'b1;
    send_block(abc);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (w_valid && round == 6'd20) begin
        hit   = 1'b1;
        rst_n = 1'b0;
      end else if (w_valid && w_ready) begin
        e = q.pop_front();
        n_cmp++;
        if ({w_word, round, last} !== {e.ew, e.eround, e.elast}) begin
          n_bad++;
          $display("FAIL midrst_word: got w=%h r=%0d required w=%h r=%0d",
                   w_word, round, e.ew, e.eround);
        end
      end
    end
    #1;
    n_cmp++;
    if (!hit || {block_ready, w_valid, w_word, round, last} !== '0) begin
      n_bad++;
      $display("FAIL midrst_zero: got hit=%b %b/%b/%h/%0d/%b required all zero",
               hit, block_ready, w_valid, w_word, round, last);
    end
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (block_ready !== 1'b0 || w_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_release: got ready=%b valid=%b required 0/0", block_ready, w_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (block_ready !== 1'b1 || w_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_ready: got ready=%b valid=%b required 1/0", block_ready, w_valid);
    end
    random_block(blk_d);
    push_block(blk_d, 64);
    send_block(blk_d);
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      @(negedge clk);
      if (w_valid && w_ready) begin
        e = q.pop_front();
        n_cmp++;
        if ({w_word, round, last} !== {e.ew, e.eround, e.elast}) begin
          n_bad++;
          $display("FAIL midrst_restart: got w=%h r=%0d l=%b required w=%h r=%0d l=%b",
                   w_word, round, last, e.ew, e.eround, e.elast);
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_timeout: got %0d words left required 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rounds16;
    exp_t e;
    int   cnt = 0;
    logic extra = 1'b0;
    q.delete();
    push_block(abc, 16);
    w16_ready = 1'b1;
    @(posedge clk); #1;
    block16       = abc;
    block16_valid = 1'b1;
    @(posedge clk); #1;
    block16_valid = 1'b0;
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      @(negedge clk);
      if (w16_valid && w16_ready) begin
        e = q.pop_front();
        cnt++;
        n_cmp++;
        if ({w16_word, round16, last16} !== {e.ew, e.eround, e.elast}) begin
          n_bad++;
          $display("FAIL r16_word: got w=%h r=%0d l=%b required w=%h r=%0d l=%b",
                   w16_word, round16, last16, e.ew, e.eround, e.elast);
        end
        if (last16) begin
          n_cmp++;
          if (round16 !== 6'd15 || w16_word !== 32'h00000018) begin
            n_bad++;
            $display("FAIL r16_last: got r=%0d w=%h required 15/00000018", round16, w16_word);
          end
        end
      end
    end
    n_cmp++;
    if (cnt != 16 || q.size() != 0) begin
      n_bad++;
      $display("FAIL r16_count: got %0d words required 16", cnt);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (w16_valid) extra = 1'b1;
    end
    n_cmp++;
    if (extra || block16_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL r16_end: got extra=%b ready=%b required 0/1", extra, block16_ready);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    block_valid   = 1'b0;
    block         = '0;
    w_ready       = 1'b0;
    block16_valid = 1'b0;
    block16       = '0;
    w16_ready     = 1'b0;
    abc           = '0;
    abc[0]        = 32'h61626380;
    abc[15]       = 32'h00000018;

    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_block_change();
    test_midreset();
    test_rounds16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
